// File: rtl/ola_trigger_delay_control.sv
// Trigger sequencer: counts stage matches after arm, then either fires at once or
// loads an external countdown with the latched delay and fires when it expires.
module ola_trigger_delay_control #(
    parameter int width       = 32,
    parameter int match_width = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_arm,
    input  logic                   in_disarm,
    input  logic                   in_match,
    input  logic [width-1:0]       cfg_delay,
    input  logic [match_width-1:0] cfg_matches,
    output logic                   cd_valid,
    output logic                   cd_run,
    output logic                   cd_setup,
    output logic [width-1:0]       cd_value,
    input  logic                   cd_expired,
    output logic                   out_trigger,
    output logic [1:0]             out_state,
    output logic [match_width-1:0] out_match_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        FIRED = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [width-1:0]       dly_q, dly_d;
    logic [match_width-1:0] tgt_q, tgt_d;
    logic [match_width-1:0] cnt_q, cnt_d;
    logic                   trig_q, trig_d;
    logic [match_width:0]   cnt_inc;
    logic                   final_match;

    // One extra bit so a saturated counter still compares as having reached any target.
    assign cnt_inc     = {1'b0, cnt_q} + (match_width + 1)'(1);
    assign final_match = (state_q == ARMED) && in_valid && in_match &&
                         (cnt_inc >= {1'b0, tgt_q});

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        dly_d    = dly_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        trig_d   = 1'b0;
        cd_run   = 1'b0;
        cd_setup = 1'b0;

        if (in_disarm) begin
            state_d = IDLE;
        end else if (in_arm) begin
            state_d = ARMED;
            dly_d   = cfg_delay;
            tgt_d   = (cfg_matches == '0) ? match_width'(1) : cfg_matches;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (in_valid && in_match && (cnt_q != '1))
                        cnt_d = cnt_q + match_width'(1);
                    if (final_match) begin
                        if (dly_q != '0) begin
                            cd_run   = 1'b1;
                            cd_setup = 1'b1;
                            state_d  = COUNT;
                        end else begin
                            // A zero delay never reaches the countdown.
                            trig_d  = 1'b1;
                            state_d = FIRED;
                        end
                    end
                end
                COUNT: begin
                    cd_run = 1'b1;
                    if (cd_expired) begin
                        trig_d  = 1'b1;
                        state_d = FIRED;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dly_q   <= '0;
            tgt_q   <= match_width'(1);
            cnt_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
        end
    end

    assign cd_valid        = in_valid;
    assign cd_value        = dly_q;
    assign out_trigger     = trig_q;
    assign out_state       = state_q;
    assign out_match_count = cnt_q;

endmodule

// File: tb/tb_ola_trigger_delay_control.sv
// Directed bench for ola_trigger_delay_control with a behavioural countdown peer.
module tb_ola_trigger_delay_control;

    logic        clock;
    logic        reset;
    logic        in_valid, in_arm, in_disarm, in_match;
    logic [31:0] cfg_delay;
    logic [15:0] cfg_matches;
    logic        cd_valid, cd_run, cd_setup, cd_expired;
    logic [31:0] cd_value;
    logic        out_trigger;
    logic [1:0]  out_state;
    logic [15:0] out_match_count;

    int n_tests = 0;
    int n_fail  = 0;

    ola_trigger_delay_control #(.width(32), .match_width(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_arm         (in_arm),
        .in_disarm      (in_disarm),
        .in_match       (in_match),
        .cfg_delay      (cfg_delay),
        .cfg_matches    (cfg_matches),
        .cd_valid       (cd_valid),
        .cd_run         (cd_run),
        .cd_setup       (cd_setup),
        .cd_value       (cd_value),
        .cd_expired     (cd_expired),
        .out_trigger    (out_trigger),
        .out_state      (out_state),
        .out_match_count(out_match_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Countdown peer: loads on setup, decrements on valid&&run, expiry is a sticky level.
    logic [31:0] m_cnt;
    logic        m_exp;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt <= '0;
            m_exp <= 1'b0;
        end else if (cd_setup) begin
            m_cnt <= cd_value;
            m_exp <= 1'b0;
        end else if (cd_valid && cd_run && m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_exp <= 1'b1;
        end
    end
    assign cd_expired = m_exp;

    typedef struct {
        logic        v, a, d, m;
        logic [31:0] dly;
        logic [15:0] mat;
        logic        x_run, x_setup;
        logic [31:0] x_val;
        logic [1:0]  x_st;
        logic [15:0] x_cnt;
        logic        x_trig;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic a, logic d, logic m, logic [31:0] dly,
                                logic [15:0] mat, logic x_run, logic x_setup,
                                logic [31:0] x_val, logic [1:0] x_st, logic [15:0] x_cnt,
                                logic x_trig);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.m = m; r.dly = dly; r.mat = mat;
        r.x_run = x_run; r.x_setup = x_setup; r.x_val = x_val;
        r.x_st = x_st; r.x_cnt = x_cnt; r.x_trig = x_trig;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic a, input logic d, input logic m);
        in_valid = v; in_arm = a; in_disarm = d; in_match = m;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic v, input logic a, input logic d, input logic m);
        set_in(v, a, d, m);
        step();
    endtask

    task automatic check_reg(input string tag, input logic [1:0] st, input logic [15:0] cnt,
                             input logic trig);
        check({tag, " state"}, 32'(out_state), 32'(st));
        check({tag, " count"}, 32'(out_match_count), 32'(cnt));
        check({tag, " trigger"}, 32'(out_trigger), 32'(trig));
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        cfg_delay   = '0;
        cfg_matches = '0;
        step();
        step();
        check_reg("reset", 2'd0, 16'd0, 1'b0);
        check("reset cd_run", 32'(cd_run), 32'd0);
        check("reset cd_setup", 32'(cd_setup), 32'd0);
        check("reset cd_value", cd_value, 32'd0);
        reset = 1'b0;
        step();

        // delay 3, one match: load on the first match, fire after three valid samples
        vecs.push_back(mk(0,1,0,0, 3,1, 0,0,0, 2'd1,0,0));
        vecs.push_back(mk(1,0,0,1, 3,1, 1,1,3, 2'd2,1,0));
        vecs.push_back(mk(1,0,0,0, 3,1, 1,0,3, 2'd2,1,0));
        vecs.push_back(mk(1,0,0,0, 3,1, 1,0,3, 2'd2,1,0));
        vecs.push_back(mk(1,0,0,0, 3,1, 1,0,3, 2'd2,1,0));
        vecs.push_back(mk(0,0,0,0, 3,1, 1,0,3, 2'd3,1,1));
        vecs.push_back(mk(0,0,0,0, 3,1, 0,0,3, 2'd3,1,0));
        // delay 0, four matches with gaps: direct fire, countdown never loaded
        vecs.push_back(mk(0,1,0,0, 0,4, 0,0,3, 2'd1,0,0));
        vecs.push_back(mk(1,0,0,1, 0,4, 0,0,0, 2'd1,1,0));
        vecs.push_back(mk(0,0,0,1, 0,4, 0,0,0, 2'd1,1,0));
        vecs.push_back(mk(1,0,0,0, 0,4, 0,0,0, 2'd1,1,0));
        vecs.push_back(mk(1,0,0,1, 0,4, 0,0,0, 2'd1,2,0));
        vecs.push_back(mk(0,0,0,0, 0,4, 0,0,0, 2'd1,2,0));
        vecs.push_back(mk(1,0,0,1, 0,4, 0,0,0, 2'd1,3,0));
        vecs.push_back(mk(1,0,0,1, 0,4, 0,0,0, 2'd3,4,1));
        vecs.push_back(mk(1,0,0,1, 0,4, 0,0,0, 2'd3,4,0));
        // zero match target treated as one; config edits after arm are ignored
        vecs.push_back(mk(0,1,0,0, 1,0, 0,0,0, 2'd1,0,0));
        vecs.push_back(mk(1,0,0,1, 7,9, 1,1,1, 2'd2,1,0));
        vecs.push_back(mk(1,0,0,0, 7,9, 1,0,1, 2'd2,1,0));
        vecs.push_back(mk(0,0,0,0, 7,9, 1,0,1, 2'd3,1,1));
        vecs.push_back(mk(0,0,0,0, 7,9, 0,0,1, 2'd3,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].m);
            cfg_delay   = vecs[i].dly;
            cfg_matches = vecs[i].mat;
            #1;
            check($sformatf("v%0d cd_valid", i), 32'(cd_valid), 32'(vecs[i].v));
            check($sformatf("v%0d cd_run", i), 32'(cd_run), 32'(vecs[i].x_run));
            check($sformatf("v%0d cd_setup", i), 32'(cd_setup), 32'(vecs[i].x_setup));
            check($sformatf("v%0d cd_value", i), cd_value, vecs[i].x_val);
            step();
            check_reg($sformatf("v%0d", i), vecs[i].x_st, vecs[i].x_cnt, vecs[i].x_trig);
        end

        // Stalled countdown: five idle clocks make no progress, long expiry gives one pulse
        cfg_delay = 2; cfg_matches = 1;
        cyc(0, 1, 0, 0);
        check_reg("stall arm", 2'd1, 16'd0, 1'b0);
        set_in(1, 0, 0, 1);
        #1;
        check("stall load setup", 32'(cd_setup), 32'd1);
        check("stall load value", cd_value, 32'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0);
            #1;
            check($sformatf("stall gap%0d run", i), 32'(cd_run), 32'd1);
            step();
            check_reg($sformatf("stall gap%0d", i), 2'd2, 16'd1, 1'b0);
        end
        cyc(1, 0, 0, 0);
        check_reg("stall s1", 2'd2, 16'd1, 1'b0);
        cyc(1, 0, 0, 0);
        check_reg("stall s2", 2'd2, 16'd1, 1'b0);
        cyc(0, 0, 0, 0);
        check_reg("stall fire", 2'd3, 16'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check_reg($sformatf("stall held%0d", i), 2'd3, 16'd1, 1'b0);
        end

        // Disarm mid-count, arm+disarm together, re-arm from FIRED
        cfg_delay = 5; cfg_matches = 1;
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 1);
        check_reg("dis count", 2'd2, 16'd1, 1'b0);
        cyc(1, 0, 0, 0);
        set_in(1, 0, 1, 0);
        #1;
        check("dis run drop", 32'(cd_run), 32'd0);
        step();
        check_reg("dis idle", 2'd0, 16'd1, 1'b0);
        cyc(0, 1, 1, 0);
        check_reg("arm+dis", 2'd0, 16'd1, 1'b0);
        cfg_delay = 0;
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 1);
        check_reg("direct fire", 2'd3, 16'd1, 1'b1);
        cyc(0, 1, 0, 0);
        check_reg("rearm fired", 2'd1, 16'd0, 1'b0);

        // Arm beats a simultaneous final match; arm in COUNT abandons the countdown
        cfg_delay = 2;
        set_in(1, 1, 0, 1);
        #1;
        check("arm+match setup", 32'(cd_setup), 32'd0);
        check("arm+match run", 32'(cd_run), 32'd0);
        step();
        check_reg("arm+match", 2'd1, 16'd0, 1'b0);
        cyc(1, 0, 0, 1);
        set_in(1, 1, 0, 0);
        #1;
        check("rearm count run", 32'(cd_run), 32'd0);
        step();
        check_reg("rearm count", 2'd1, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            check_reg($sformatf("abandon%0d", i), 2'd1, 16'd0, 1'b0);
        end

        // Asynchronous reset mid-count
        cfg_delay = 4;
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        check_reg("pre-reset", 2'd2, 16'd1, 1'b0);
        set_in(1, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_reg("async reset", 2'd0, 16'd0, 1'b0);
        check("async reset run", 32'(cd_run), 32'd0);
        check("async reset setup", 32'(cd_setup), 32'd0);
        check("async reset value", cd_value, 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0);
            check_reg($sformatf("post-reset%0d", i), 2'd0, 16'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
